// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline control slice.
//   REG_AW_DEF   default register-address width
//   pipe_state_t pipeline controller FSM state encoding
//   fwd_sel_t    EX-stage operand source select encoding
package mips_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_IWAIT = 2'b01,
    ST_DWAIT = 2'b10
  } pipe_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/mips_fwd_unit.sv
// mips_fwd_unit: selects the source of one EX-stage operand.
//   ex_src                 EX-stage source register being read
//   mem_rd / mem_regwrite  MEM-stage destination and write enable
//   wb_rd / wb_regwrite    WB-stage destination and write enable
//   sel                    FWD_MEM, FWD_WB or FWD_RF
// MEM wins over WB because it holds the younger result. Register 0 never
// forwards, since writes to it are discarded.
module mips_fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: stall/flush/forward controller for a 5-stage MIPS pipeline.
//   Clk, Rst                       clock, asynchronous active-high reset
//   if_hit, dm_hit, mem_access     cache status from the fetch and memory stages
//   id_*, ex_*, mem_*, wb_*        register fields and control bits per stage
//   branch_taken                   branch resolved taken in EX
//   *_en, *_flush                  pipeline-register load enables / bubble inserts
//   fwd_a, fwd_b                   EX operand selects (00 regfile, 01 WB, 10 MEM)
//   state                          00 RUN, 01 IWAIT, 10 DWAIT
//   stall_cnt, imiss_cnt, dmiss_cnt saturating statistics counters
// Build option: define MIPS_PIPE_FWD_EN to enable operand forwarding; without
// it every RAW dependence on an in-flight writer stalls ID instead.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_hit,
  input  logic              dm_hit,
  input  logic              mem_access,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  imiss_cnt,
  output logic [CNT_W-1:0]  dmiss_cnt
);

  pipe_state_t      state_q;
  pipe_state_t      state_nx;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] imiss_q;
  logic [CNT_W-1:0] dmiss_q;
  fwd_sel_t         sel_a;
  fwd_sel_t         sel_b;
  logic             d_wait;
  logic             raw_stall;

  // A source register is hazardous only if it is read, nonzero, and matches
  // a destination that is actually being written.
  function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                   input logic              used,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              wr);
    return used && wr && (src != '0) && (src == dst);
  endfunction

  mips_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_src      (ex_rs),
    .mem_rd      (mem_rd),
    .mem_regwrite(mem_regwrite),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .sel         (sel_a)
  );

  mips_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_src      (ex_rt),
    .mem_rd      (mem_rd),
    .mem_regwrite(mem_regwrite),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .sel         (sel_b)
  );

`ifdef MIPS_PIPE_FWD_EN
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  // With forwarding only a load feeding the very next instruction must wait.
  assign raw_stall = src_hit(id_rs, id_rs_used, ex_rd, ex_memread) |
                     src_hit(id_rt, id_rt_used, ex_rd, ex_memread);

  assign fwd_a = Rst ? FWD_RF : sel_a;
  assign fwd_b = Rst ? FWD_RF : sel_b;
`else
  logic ex_writes;
  logic unused_fwd;
  assign ex_writes  = ex_regwrite | ex_memread;
  assign unused_fwd = ^{sel_a, sel_b};

  // Without forwarding ID waits until every older writer has retired.
  assign raw_stall = src_hit(id_rs, id_rs_used, ex_rd,  ex_writes)    |
                     src_hit(id_rt, id_rt_used, ex_rd,  ex_writes)    |
                     src_hit(id_rs, id_rs_used, mem_rd, mem_regwrite) |
                     src_hit(id_rt, id_rt_used, mem_rd, mem_regwrite) |
                     src_hit(id_rs, id_rs_used, wb_rd,  wb_regwrite)  |
                     src_hit(id_rt, id_rt_used, wb_rd,  wb_regwrite);

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  // A data miss keeps holding the pipe in DWAIT until the hit arrives, even
  // if mem_access has since dropped.
  assign d_wait = !dm_hit && (mem_access || (state_q == ST_DWAIT));

  // Priority chain: D-miss, branch, RAW stall, I-miss, normal flow. A RAW
  // stall that coincides with a fetch miss still records the IWAIT entry.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_nx    = ST_RUN;
    if (Rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (d_wait) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_nx    = ST_DWAIT;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (raw_stall || !if_hit) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (!if_hit && (state_q != ST_DWAIT)) begin
        state_nx = ST_IWAIT;
      end
    end
  end

  // State and statistics; counters stick at all-ones instead of wrapping.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      imiss_q <= '0;
      dmiss_q <= '0;
    end else begin
      state_q <= state_nx;
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if ((state_q == ST_RUN) && (state_nx == ST_IWAIT) && (imiss_q != '1)) begin
        imiss_q <= imiss_q + 1'b1;
      end
      if ((state_q != ST_DWAIT) && (state_nx == ST_DWAIT) && (dmiss_q != '1)) begin
        dmiss_q <= dmiss_q + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign imiss_cnt = imiss_q;
  assign dmiss_cnt = dmiss_q;

endmodule

// File: doc/mips_pipe_ctrl.md
MIPS_PIPE_CTRL -- requirements
Module: mips_pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each saturating statistics counter.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 SHALL have ports (name, direction, width, meaning):
- Clk  in  1  rising-edge clock
- Rst  in  1  async active-high reset
- if_hit  in  1  instruction fetch hit
- dm_hit  in  1  data memory hit
- mem_access  in  1  MEM-stage instruction reads or writes memory
- id_rs, id_rt  in  REG_AW  ID-stage source registers
- id_rs_used, id_rt_used  in  1  ID source actually read
- ex_rs, ex_rt  in  REG_AW  EX-stage source registers
- ex_rd  in  REG_AW  EX-stage destination (after RegDst mux)
- ex_regwrite, ex_memread  in  1  EX-stage control bits
- mem_rd  in  REG_AW  MEM-stage destination
- mem_regwrite  in  1  MEM-stage RegWrite
- wb_rd  in  REG_AW  WB-stage destination
- wb_regwrite  in  1  WB-stage RegWrite
- branch_taken  in  1  EX-stage branch resolved taken
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage-register load enables
- ifid_flush, idex_flush, memwb_flush  out  1  load bubble (all control zero) into that register
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- state  out  2  FSM state: 00 RUN, 01 IWAIT, 10 DWAIT
- stall_cnt, imiss_cnt, dmiss_cnt  out  CNT_W  saturating statistics counters

Function
REQ-005 SHALL implement FSM states RUN, IWAIT, DWAIT; outputs combinational from state and inputs, state/counters registered.
REQ-006 SHALL apply priority each cycle: D-miss > branch > load-use > I-miss > normal.
REQ-007 D-miss (mem_access=1, dm_hit=0): pc/ifid/idex/exmem enables 0, memwb_en=1, memwb_flush=1; next state DWAIT.
REQ-008 SHALL stay in DWAIT while dm_hit=0; on dm_hit=1 outputs equal RUN evaluation that cycle and next state RUN.
REQ-009 Branch (branch_taken=1, no D-miss): all enables 1, ifid_flush=1, idex_flush=1; next state RUN, aborting any IWAIT.
REQ-010 Load-use (ex_memread=1, ex_rd!=0, ex_rd equals id_rs with id_rs_used or id_rt with id_rt_used): pc_en=0, ifid_en=0, idex_flush=1, rest enabled; exactly one bubble.
REQ-011 I-miss (if_hit=0): pc_en=0, ifid_en=0, idex_flush=1, EX/MEM/WB continue draining; next state IWAIT; IWAIT with if_hit=1 behaves as RUN, next RUN.
REQ-012 Normal: all enables 1, all flushes 0.
REQ-013 fwd_a=10 when mem_regwrite=1, mem_rd!=0, mem_rd==ex_rs; else 01 when wb_regwrite=1, wb_rd!=0, wb_rd==ex_rs; else 00; fwd_b likewise on ex_rt.
REQ-014 Register 0 SHALL never match any hazard or forwarding comparison.
REQ-015 stall_cnt SHALL increment each cycle pc_en=0; imiss_cnt on each RUN->IWAIT; dmiss_cnt on each entry to DWAIT; all saturate at 2^CNT_W-1.

Reset
REQ-016 Rst high: state=RUN, all counters 0, immediately (asynchronous).
REQ-017 While Rst high: all *_en=0, all *_flush=1, fwd_a=fwd_b=00; reset mid-miss SHALL discard the miss.

Configuration
REQ-018 Macro MIPS_PIPE_FWD_EN defined: forwarding per REQ-013; only load-use stalls for RAW.
REQ-019 MIPS_PIPE_FWD_EN undefined: fwd_a=fwd_b=00; any ID source matching a nonzero writing EX, MEM or WB destination stalls as REQ-010.

Structure
REQ-020 Shared package mips_pkg SHALL hold state encodings, fwd select encodings and REG_AW default.
REQ-021 Forwarding compare SHALL be sub-module mips_fwd_unit, instantiated twice (A, B).

Verification
REQ-022 mem_rd=3, mem_regwrite=1, ex_rs=3 -> fwd_a=10; also wb_rd=3 -> still 10.
REQ-023 ex_memread=1, ex_rd=8, id_rt=8, id_rt_used=1 -> one cycle pc_en=0, idex_flush=1, stall_cnt=1.
REQ-024 if_hit=0 for 4 cycles -> state IWAIT, pc_en=0 x4, exmem_en=1, imiss_cnt=1, stall_cnt=4.
REQ-025 mem_access=1, dm_hit=0, branch_taken=1 for 3 cycles -> DWAIT, exmem_en=0; after dm_hit=1 flush IF/ID, ID/EX.
REQ-026 Rst pulse during DWAIT -> state=00, counters 0, enables 0 same cycle.
REQ-027 Without MIPS_PIPE_FWD_EN, wb_rd=5, wb_regwrite=1, id_rs=5 -> stall, fwd_a=00.
